sfft_frame_scheduler: RTL and testbench

//  Sequences the single-stage SFFT pipeline between the audio codec and the peak finder.
//  - Captures each codec sample.
//  - Pulses the pipeline's advance input once per sample, then enforces the per-sample calculation window.
//  - Every HOP samples, reads the FREQS magnitude bins through the pipeline's address port.
//  - Streams the bins downstream with a valid/ready handshake.

---
 rtl/sfft_pkg.sv | 24 ++
 rtl/sfft_bin_skid.sv | 49 ++++
 rtl/sfft_frame_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sfft_frame_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfft_pkg.sv
// Shared types for the SFFT frame scheduler.
// Widths, bin count and scheduler state encoding.
package sfft_pkg;

   localparam int SFFT_INPUT_WIDTH   = 16;
   localparam int SFFT_OUTPUT_WIDTH  = 16;
   localparam int FREQS              = 16;
   localparam int NFFT               = 4;
   localparam int TIME_COUNTER_WIDTH = 16;

   typedef logic [SFFT_INPUT_WIDTH-1:0]   sample_t;
   typedef logic [SFFT_OUTPUT_WIDTH-1:0]  ampl_t;
   typedef logic [NFFT-1:0]               bin_t;
   typedef logic [TIME_COUNTER_WIDTH-1:0] frame_cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      ADVANCE,
      SETTLE,
      READ,
      EMIT
   } sched_state_t;

endpackage

// File: rtl/sfft_bin_skid.sv
// Bin output register: holds data/index/last stable
// while valid is high until the consumer takes it.
module sfft_bin_skid
   import sfft_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_load,
   input  logic  i_flush,
   input  ampl_t i_data,
   input  bin_t  i_index,
   input  logic  i_last,
   input  logic  i_ready,
   output logic  o_valid,
   output ampl_t o_data,
   output bin_t  o_index,
   output logic  o_last
);

   logic  r_valid;
   ampl_t r_data;
   bin_t  r_index;
   logic  r_last;

   // Load a bin, drop it on accept or abort.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
         r_last  <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_index <= i_index;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_index = r_index;
   assign o_last  = r_last;

endmodule

// File: rtl/sfft_frame_scheduler.sv
// Sequences codec samples into the SFFT pipeline and
// streams one frame of bins downstream every HOP samples.
module sfft_frame_scheduler
   import sfft_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 400,
   parameter int unsigned HOP           = 8,
   parameter int unsigned BINS          = FREQS,
   parameter int unsigned READ_LATENCY  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  sample_t    sample_in,
   input  logic       sample_valid,
   output logic       sample_dropped,
   output sample_t    sfft_sample,
   output logic       sfft_advance,
   input  logic       sfft_out_valid,
   output logic       sfft_out_read,
   input  logic       sfft_read_error,
   output bin_t       sfft_addr,
   input  ampl_t      sfft_data,
   output ampl_t      bin_data,
   output bin_t       bin_index,
   output logic       bin_valid,
   output logic       bin_last,
   input  logic       bin_ready,
   output logic       frame_error,
   output frame_cnt_t frame_count
);

   localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  HOP_MAX     = 8'(HOP);
   localparam bin_t        LAST_BIN    = bin_t'(BINS - 1);
   localparam logic [1:0]  RD_LAST     = 2'(READ_LATENCY);

   sched_state_t r_state;
   sample_t      r_hold_data;
   logic         r_hold_full;
   logic         r_dropped;
   logic [7:0]   r_hop;
   logic [15:0]  r_settle;
   logic [1:0]   r_rd;
   bin_t         r_bin;
   logic         r_advance;
   logic         r_out_read;
   logic         r_frame_err;
   frame_cnt_t   r_frame_cnt;

   logic w_empty;
   logic w_err;
   logic w_capture;
   logic w_accept;

   assign w_empty   = (r_state == ADVANCE);
   assign w_err     = sfft_read_error &&
                      ((r_state == READ) || (r_state == EMIT));
   assign w_capture = (r_state == READ) && (r_rd == RD_LAST) && !w_err;
   assign w_accept  = bin_valid && bin_ready;

   // One-entry sample hold; a new sample survives a same-cycle empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         r_dropped <= 1'b0;
         if (sample_valid && (!r_hold_full || w_empty)) begin
            r_hold_data <= sample_in;
            r_hold_full <= 1'b1;
         end else begin
            if (sample_valid) begin
               r_dropped <= 1'b1;
            end
            if (w_empty) begin
               r_hold_full <= 1'b0;
            end
         end
      end
   end

   // Scheduler FSM: advance, settle, then read/emit a frame on hop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_hop       <= '0;
         r_settle    <= '0;
         r_rd        <= '0;
         r_bin       <= '0;
         r_advance   <= 1'b0;
         r_out_read  <= 1'b0;
         r_frame_err <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_advance   <= 1'b0;
         r_frame_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (r_hold_full) begin
                  r_state   <= ADVANCE;
                  r_advance <= 1'b1;
               end
            end
            ADVANCE: begin
               if (r_hop != HOP_MAX) begin
                  r_hop <= r_hop + 8'd1;
               end
               r_settle <= SETTLE_INIT;
               r_state  <= SETTLE;
            end
            SETTLE: begin
               if (r_settle == 16'd0) begin
                  if ((r_hop == HOP_MAX) && sfft_out_valid) begin
                     r_hop      <= '0;
                     r_rd       <= '0;
                     r_out_read <= 1'b1;
                     r_state    <= READ;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_settle <= r_settle - 16'd1;
               end
            end
            READ: begin
               if (w_err) begin
                  r_bin       <= '0;
                  r_out_read  <= 1'b0;
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else if (r_rd == RD_LAST) begin
                  r_state <= EMIT;
               end else begin
                  r_rd <= r_rd + 2'd1;
               end
            end
            EMIT: begin
               if (w_err) begin
                  r_bin       <= '0;
                  r_out_read  <= 1'b0;
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else if (w_accept) begin
                  if (r_bin == LAST_BIN) begin
                     r_bin       <= '0;
                     r_out_read  <= 1'b0;
                     r_frame_cnt <= r_frame_cnt + frame_cnt_t'(1);
                     r_state     <= IDLE;
                  end else begin
                     r_bin   <= r_bin + bin_t'(1);
                     r_rd    <= '0;
                     r_state <= READ;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   sfft_bin_skid u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_capture),
      .i_flush (w_err),
      .i_data  (sfft_data),
      .i_index (r_bin),
      .i_last  (r_bin == LAST_BIN),
      .i_ready (bin_ready),
      .o_valid (bin_valid),
      .o_data  (bin_data),
      .o_index (bin_index),
      .o_last  (bin_last)
   );

   assign sample_dropped = r_dropped;
   assign sfft_sample    = r_hold_data;
   assign sfft_advance   = r_advance;
   assign sfft_out_read  = r_out_read;
   assign sfft_addr      = r_bin;
   assign frame_error    = r_frame_err;
   assign frame_count    = r_frame_cnt;

endmodule

// File: tb/tb_sfft_frame_scheduler.sv
// Scoreboard bench for the SFFT frame scheduler with a
// one-clock-latency pipeline memory model.
module tb_sfft_frame_scheduler;
   import sfft_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   sample_t    sample_in;
   logic       sample_valid;
   logic       sample_dropped;
   sample_t    sfft_sample;
   logic       sfft_advance;
   logic       sfft_out_valid;
   logic       sfft_out_read;
   logic       sfft_read_error;
   bin_t       sfft_addr;
   ampl_t      sfft_data;
   ampl_t      bin_data;
   bin_t       bin_index;
   logic       bin_valid;
   logic       bin_last;
   logic       bin_ready;
   logic       frame_error;
   frame_cnt_t frame_count;

   always #5 clk = ~clk;

   sfft_frame_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .sample_dropped  (sample_dropped),
      .sfft_sample     (sfft_sample),
      .sfft_advance    (sfft_advance),
      .sfft_out_valid  (sfft_out_valid),
      .sfft_out_read   (sfft_out_read),
      .sfft_read_error (sfft_read_error),
      .sfft_addr       (sfft_addr),
      .sfft_data       (sfft_data),
      .bin_data        (bin_data),
      .bin_index       (bin_index),
      .bin_valid       (bin_valid),
      .bin_last        (bin_last),
      .bin_ready       (bin_ready),
      .frame_error     (frame_error),
      .frame_count     (frame_count)
   );

   // pipeline memory: bin value = {tag, 0, address}
   logic [7:0] tag;
   ampl_t      mem_q = '0;
   always @(posedge clk) mem_q <= {tag, 4'h0, sfft_addr};
   assign sfft_data = mem_q;

   typedef struct {
      ampl_t data;
      bin_t  idx;
      logic  last;
   } bin_exp_t;

   bin_exp_t bq[$];
   sample_t  aq[$];
   int errors = 0;
   int checks = 0;
   int drop_cnt = 0;
   int ferr_cnt = 0;
   int rd_cycles = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] t, input int n);
      bin_exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data = {t, 4'h0, 4'(i)};
         e.idx  = 4'(i);
         e.last = (i == 15);
         bq.push_back(e);
      end
   endtask

   // monitor: advances, bins, stall stability, pulse counters
   bin_exp_t be;
   sample_t  ae;
   logic     held = 1'b0;
   ampl_t    hd;
   bin_t     hi;
   logic     hl;

   always @(negedge clk) begin
      if (sample_dropped) drop_cnt++;
      if (frame_error) ferr_cnt++;
      if (sfft_out_read) rd_cycles++;
      if (sfft_advance) begin
         if (aq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL adv_unexpected: sample %0h", sfft_sample);
         end else begin
            ae = aq.pop_front();
            check("adv_sample", 32'(sfft_sample), 32'(ae));
         end
      end
      if (bin_valid) begin
         if (held) begin
            check("stall_data", 32'(bin_data), 32'(hd));
            check("stall_index", 32'(bin_index), 32'(hi));
            check("stall_last", 32'(bin_last), 32'(hl));
         end
         if (!bin_ready) begin
            held = 1'b1;
            hd = bin_data;
            hi = bin_index;
            hl = bin_last;
         end else begin
            held = 1'b0;
            if (bq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bin_unexpected: index %0d data %0h",
                        bin_index, bin_data);
            end else begin
               be = bq.pop_front();
               check("bin_data", 32'(bin_data), 32'(be.data));
               check("bin_index", 32'(bin_index), 32'(be.idx));
               check("bin_last", 32'(bin_last), 32'(be.last));
            end
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic strobe(input sample_t v);
      @(posedge clk);
      #1;
      sample_in = v;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic sample(input sample_t v);
      aq.push_back(v);
      strobe(v);
      repeat (498) @(posedge clk);
   endtask

   task automatic wait_bin(input bin_t idx);
      int n = 0;
      while (!(bin_valid && bin_index == idx) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL wait_bin: bin %0d never valid, wanted within 2000", idx);
      end
   endtask

   task automatic wait_read(input bin_t idx);
      int n = 0;
      while (!(sfft_out_read && sfft_addr == idx && !bin_valid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL wait_read: addr %0d never read, wanted within 2000", idx);
      end
   endtask

   int n;
   int d0;

   initial begin
      reset = 1'b0;
      sample_in = '0;
      sample_valid = 1'b0;
      sfft_out_valid = 1'b1;
      sfft_read_error = 1'b0;
      bin_ready = 1'b1;
      tag = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bin_valid", 32'(bin_valid), 0);
      check("rst_advance", 32'(sfft_advance), 0);
      check("rst_out_read", 32'(sfft_out_read), 0);
      check("rst_frame_count", 32'(frame_count), 0);
      check("rst_sfft_sample", 32'(sfft_sample), 0);
      check("rst_bin_data", 32'(bin_data), 0);
      @(negedge clk);
      reset = 1'b1;

      // 1: eight samples make one frame, latency checks
      tag = 8'h01;
      aq.push_back(16'd10);
      strobe(16'd10);
      check("adv_lat_early", 32'(sfft_advance), 0);
      @(posedge clk);
      #1;
      check("adv_lat", 32'(sfft_advance), 1);
      repeat (496) @(posedge clk);
      for (int s = 1; s < 7; s++) sample(sample_t'(10 + s));
      push_frame(8'h01, 16);
      aq.push_back(16'd17);
      strobe(16'd17);
      @(posedge clk);
      #1;
      check("adv_lat8", 32'(sfft_advance), 1);
      n = 0;
      while (!bin_valid && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("first_bin_lat", 32'(n), 403);
      repeat (100) @(posedge clk);
      check("t1_frame_count", 32'(frame_count), 1);
      check("t1_bins_done", 32'(bq.size()), 0);

      // 2: stall bin 5 for ten clocks
      tag = 8'h02;
      for (int s = 0; s < 7; s++) sample(sample_t'(20 + s));
      push_frame(8'h02, 16);
      aq.push_back(16'd27);
      strobe(16'd27);
      wait_bin(4'd5);
      bin_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("stall_valid", 32'(bin_valid), 1);
      check("stall_idx5", 32'(bin_index), 5);
      bin_ready = 1'b1;
      repeat (100) @(posedge clk);
      check("t2_frame_count", 32'(frame_count), 2);
      check("t2_bins_done", 32'(bq.size()), 0);

      // 3: two strobes during settle, second dropped
      d0 = drop_cnt;
      aq.push_back(16'd60);
      strobe(16'd60);
      repeat (100) @(posedge clk);
      aq.push_back(16'd70);
      strobe(16'd70);
      @(posedge clk);
      strobe(16'd71);
      repeat (3) @(posedge clk);
      #1;
      check("drop_once", 32'(drop_cnt - d0), 1);
      check("hold_kept", 32'(sfft_sample), 70);
      repeat (800) @(posedge clk);
      check("t3_adv_done", 32'(aq.size()), 0);

      // 4: pipeline not primed at the hop boundary
      for (int s = 0; s < 5; s++) sample(sample_t'(80 + s));
      sfft_out_valid = 1'b0;
      d0 = rd_cycles;
      sample(16'd85);
      check("no_read_hop8", 32'(rd_cycles - d0), 0);
      check("t4_count_hold", 32'(frame_count), 2);
      sfft_out_valid = 1'b1;
      tag = 8'h04;
      push_frame(8'h04, 16);
      sample(16'd86);
      check("t4_deferred", 32'(frame_count), 3);
      d0 = rd_cycles;
      for (int s = 0; s < 7; s++) sample(sample_t'(90 + s));
      check("hop_restart", 32'(rd_cycles - d0), 0);
      tag = 8'h05;
      push_frame(8'h05, 16);
      sample(16'd97);
      check("t4_frame_count", 32'(frame_count), 4);

      // 5: read error during bin 3
      for (int s = 0; s < 7; s++) sample(sample_t'(100 + s));
      tag = 8'h06;
      push_frame(8'h06, 3);
      d0 = ferr_cnt;
      aq.push_back(16'd107);
      strobe(16'd107);
      wait_read(4'd3);
      sfft_read_error = 1'b1;
      @(posedge clk);
      #1;
      sfft_read_error = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("ferr_once", 32'(ferr_cnt - d0), 1);
      check("t5_count_same", 32'(frame_count), 4);
      check("t5_bin_valid", 32'(bin_valid), 0);
      check("t5_out_read", 32'(sfft_out_read), 0);
      check("t5_bins_done", 32'(bq.size()), 0);
      repeat (50) @(posedge clk);
      tag = 8'h07;
      for (int s = 0; s < 7; s++) sample(sample_t'(110 + s));
      push_frame(8'h07, 16);
      sample(16'd117);
      check("t5_next_frame", 32'(frame_count), 5);

      // 6: reset during EMIT of bin 7
      for (int s = 0; s < 7; s++) sample(sample_t'(120 + s));
      tag = 8'h08;
      push_frame(8'h08, 7);
      d0 = ferr_cnt;
      aq.push_back(16'd127);
      strobe(16'd127);
      wait_bin(4'd7);
      bin_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("r6_bin_valid", 32'(bin_valid), 0);
      check("r6_bin_data", 32'(bin_data), 0);
      check("r6_bin_index", 32'(bin_index), 0);
      check("r6_out_read", 32'(sfft_out_read), 0);
      check("r6_addr", 32'(sfft_addr), 0);
      check("r6_frame_count", 32'(frame_count), 0);
      check("r6_sfft_sample", 32'(sfft_sample), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bin_ready = 1'b1;
      check("r6_no_ferr", 32'(ferr_cnt - d0), 0);
      tag = 8'h09;
      for (int s = 0; s < 7; s++) sample(sample_t'(130 + s));
      push_frame(8'h09, 16);
      sample(16'd137);
      check("r6_frame_count", 32'(frame_count), 1);
      check("end_bins_empty", 32'(bq.size()), 0);
      check("end_adv_empty", 32'(aq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
